// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce, BCD M:SS entry and a write/ack handoff
// of the committed cook time (seconds) plus start/stop controls for the timer.
module keypad_entry #(
  parameter int unsigned SCAN_DIV = 5000,
  parameter int unsigned DEBOUNCE = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  input  logic        write_ack,
  output logic        write,
  output logic [9:0]  Time,
  output logic        start,
  output logic        stop,
  output logic [11:0] entry
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [3:0] K_A    = 4'd10;
  localparam logic [3:0] K_B    = 4'd11;
  localparam logic [3:0] K_C    = 4'd12;
  localparam logic [3:0] K_D    = 4'd13;
  localparam logic [3:0] K_STAR = 4'd14;
  localparam logic [3:0] K_HASH = 4'd15;

  typedef enum logic [1:0] {SCAN, DEB, WAIT_REL} scan_state_e;
  typedef enum logic       {HS_IDLE, HS_WRITE} hs_state_e;

  scan_state_e scan_q, scan_d;
  hs_state_e   hs_q, hs_d;

  logic [3:0]       col_m_q, cols_q;
  logic [3:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [3:0]       col_lat_q, col_lat_d;
  logic [1:0]       key_row_q, key_row_d;
  logic [1:0]       key_col_q, key_col_d;
  logic             evt_q, evt_d;

  logic        write_q, write_d;
  logic [9:0]  time_q, time_d;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic [11:0] entry_q, entry_d;

  logic [1:0]  row_enc_c;
  logic [1:0]  col_enc_c;
  logic [3:0]  key_code_c;
  logic [3:0]  row_rot_c;

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_m_q <= 4'hF;
      cols_q  <= 4'hF;
    end else begin
      col_m_q <= col;
      cols_q  <= col_m_q;
    end
  end

  always_comb begin
    row_rot_c = {row_q[2:0], row_q[3]};
    case (row_q)
      4'b1110: row_enc_c = 2'd0;
      4'b1101: row_enc_c = 2'd1;
      4'b1011: row_enc_c = 2'd2;
      default: row_enc_c = 2'd3;
    endcase
    // Lowest-index low column wins
    col_enc_c = 2'd3;
    if (!cols_q[2]) col_enc_c = 2'd2;
    if (!cols_q[1]) col_enc_c = 2'd1;
    if (!cols_q[0]) col_enc_c = 2'd0;
  end

  always_comb begin
    case ({key_row_q, key_col_q})
      4'h0:    key_code_c = 4'd1;
      4'h1:    key_code_c = 4'd2;
      4'h2:    key_code_c = 4'd3;
      4'h3:    key_code_c = K_A;
      4'h4:    key_code_c = 4'd4;
      4'h5:    key_code_c = 4'd5;
      4'h6:    key_code_c = 4'd6;
      4'h7:    key_code_c = K_B;
      4'h8:    key_code_c = 4'd7;
      4'h9:    key_code_c = 4'd8;
      4'hA:    key_code_c = 4'd9;
      4'hB:    key_code_c = K_C;
      4'hC:    key_code_c = K_STAR;
      4'hD:    key_code_c = 4'd0;
      4'hE:    key_code_c = K_HASH;
      default: key_code_c = K_D;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q    <= SCAN;
      row_q     <= 4'b1110;
      div_q     <= '0;
      deb_q     <= '0;
      col_lat_q <= 4'hF;
      key_row_q <= 2'd0;
      key_col_q <= 2'd0;
      evt_q     <= 1'b0;
    end else begin
      scan_q    <= scan_d;
      row_q     <= row_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      col_lat_q <= col_lat_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      evt_q     <= evt_d;
    end
  end

  // Scan / debounce / release FSM; emits one event per physical press
  always_comb begin
    scan_d    = scan_q;
    row_d     = row_q;
    div_d     = div_q;
    deb_d     = deb_q;
    col_lat_d = col_lat_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    evt_d     = 1'b0;
    case (scan_q)
      SCAN: begin
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_d = '0;
          if (cols_q != 4'hF) begin
            col_lat_d = cols_q;
            key_row_d = row_enc_c;
            key_col_d = col_enc_c;
            deb_d     = '0;
            scan_d    = DEB;
          end else begin
            row_d = row_rot_c;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DEB: begin
        if (cols_q == col_lat_q) begin
          if (deb_q == DEB_W'(DEBOUNCE - 1)) begin
            evt_d  = 1'b1;
            deb_d  = '0;
            scan_d = WAIT_REL;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end else begin
          scan_d = SCAN;
          row_d  = row_rot_c;
          div_d  = '0;
        end
      end
      WAIT_REL: begin
        if (cols_q == 4'hF) begin
          if (deb_q == DEB_W'(DEBOUNCE - 1)) begin
            deb_d  = '0;
            div_d  = '0;
            row_d  = row_rot_c;
            scan_d = SCAN;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end else begin
          deb_d = '0;
        end
      end
      default: scan_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= HS_IDLE;
      write_q <= 1'b0;
      time_q  <= 10'd0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      entry_q <= 12'd0;
    end else begin
      hs_q    <= hs_d;
      write_q <= write_d;
      time_q  <= time_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      entry_q <= entry_d;
    end
  end

  // Key actions and write/ack handshake; Time only changes on a valid enter
  always_comb begin
    hs_d    = hs_q;
    time_d  = time_q;
    start_d = start_q;
    stop_d  = 1'b0;
    entry_d = entry_q;
    if (hs_q == HS_WRITE && write_ack) begin
      hs_d = HS_IDLE;
    end
    if (evt_q) begin
      if (key_code_c <= 4'd9) begin
        entry_d = {entry_q[7:0], key_code_c};
      end else begin
        case (key_code_c)
          K_C, K_STAR: entry_d = 12'd0;
          K_HASH: begin
            if (hs_q == HS_IDLE) begin
              if (entry_q[7:4] > 4'd5) begin
                entry_d = 12'd0;
              end else begin
                time_d  = 10'(entry_q[11:8]) * 10'd60
                        + 10'(entry_q[7:4]) * 10'd10
                        + 10'(entry_q[3:0]);
                start_d = 1'b0;
                hs_d    = HS_WRITE;
              end
            end
          end
          K_A: begin
            if (time_q != 10'd0 && hs_q == HS_IDLE) start_d = 1'b1;
          end
          K_B: begin
            start_d = 1'b0;
            stop_d  = 1'b1;
          end
          default: ;
        endcase
      end
    end
    write_d = (hs_d == HS_WRITE);
  end

  assign row   = row_q;
  assign write = write_q;
  assign Time  = time_q;
  assign start = start_q;
  assign stop  = stop_q;
  assign entry = entry_q;

endmodule
